// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RV32I core: sequences ALU, memory port, PC, IR and
// register file. Control word is registered alongside the state; strobes are masked in reset.
module multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic        RegWrite,
    output logic [2:0]  ImmSrc,
    output logic        instr_done,
    output logic        illegal_instr
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StJalr1    = 4'd11,
        StJalr2    = 4'd12,
        StLui      = 4'd13
    } state_e;

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       regwrite;
        logic       done;
    } ctrl_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_instr;

    assign op           = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7b5     = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    state_e     state_q;
    state_e     state_d;
    state_e     decode_next;
    ctrl_t      ctrl_q;
    logic       op_known;
    logic [2:0] alu_exec;
    logic [2:0] imm_dec;

    // Control word for a state; aluop only matters for the execute states.
    function automatic ctrl_t ctrl_of(input state_e s, input logic [2:0] aluop);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.irwrite = 1'b1;
                c.alusrcb = 2'b10;
                c.resultsrc = 2'b10;
                c.pcwrite = 1'b1;
            end
            StDecode: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            StMemAdr, StJalr1: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            StMemRead: begin
                c.adrsrc = 1'b1;
            end
            StMemWb: begin
                c.resultsrc = 2'b01;
                c.regwrite = 1'b1;
                c.done = 1'b1;
            end
            StMemWrite: begin
                c.adrsrc = 1'b1;
                c.memwrite = 1'b1;
                c.done = 1'b1;
            end
            StExecR: begin
                c.alusrca = 2'b10;
                c.alucontrol = aluop;
            end
            StExecI: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.alucontrol = aluop;
            end
            StAluWb: begin
                c.regwrite = 1'b1;
                c.done = 1'b1;
            end
            StBranch: begin
                c.alusrca = 2'b10;
                c.alucontrol = AluSub;
                c.done = 1'b1;
            end
            StJal, StJalr2: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b10;
                c.pcwrite = 1'b1;
            end
            StLui: begin
                c.resultsrc = 2'b11;
                c.regwrite = 1'b1;
                c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        op_known    = 1'b1;
        decode_next = StFetch;
        case (op)
            OpLoad, OpStore: decode_next = StMemAdr;
            OpR:             decode_next = StExecR;
            OpI:             decode_next = StExecI;
            OpBranch:        decode_next = StBranch;
            OpJal:           decode_next = StJal;
            OpJalr:          decode_next = StJalr1;
            OpLui:           decode_next = StLui;
            OpAuipc:         decode_next = StAluWb;
            default:         op_known = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  alu_exec = (op == OpR && funct7b5) ? AluSub : AluAdd;
            3'b111:  alu_exec = AluAnd;
            3'b110:  alu_exec = AluOr;
            3'b100:  alu_exec = AluXor;
            3'b010:  alu_exec = AluSlt;
            default: alu_exec = AluAdd;
        endcase
    end

    always_comb begin
        case (op)
            OpStore:        imm_dec = 3'b001;
            OpBranch:       imm_dec = 3'b010;
            OpLui, OpAuipc: imm_dec = 3'b011;
            OpJal:          imm_dec = 3'b100;
            default:        imm_dec = 3'b000;
        endcase
    end

    always_comb begin
        case (state_q)
            StFetch:    state_d = StDecode;
            StDecode:   state_d = decode_next;
            StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
            StMemRead:  state_d = StMemWb;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StJalr1:    state_d = StJalr2;
            StJalr2:    state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= state_e'(RESET_STATE);
            ctrl_q  <= ctrl_of(state_e'(RESET_STATE), AluAdd);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d, alu_exec);
        end
    end

    logic live;
    logic decode_ill;
    logic br_take;

    // Unused encodings (14, 15) present an all-zero control word until the FSM recovers.
    assign live       = !rst && (state_q <= StLui);
    assign decode_ill = live && (state_q == StDecode) && !op_known;
    assign br_take    = (funct3 == 3'b000 && Zero) || (funct3 == 3'b001 && !Zero);

    assign PCWrite       = live && (ctrl_q.pcwrite || (state_q == StBranch && br_take));
    assign AdrSrc        = live && ctrl_q.adrsrc;
    assign MemWrite      = live && ctrl_q.memwrite;
    assign IRWrite       = live && ctrl_q.irwrite;
    assign ResultSrc     = live ? ctrl_q.resultsrc : 2'b00;
    assign ALUSrcA       = live ? ctrl_q.alusrca : 2'b00;
    assign ALUSrcB       = live ? ctrl_q.alusrcb : 2'b00;
    assign ALUControl    = live ? ctrl_q.alucontrol : 3'b000;
    assign RegWrite      = live && ctrl_q.regwrite;
    assign ImmSrc        = rst ? 3'b000 : imm_dec;
    assign instr_done    = live && (ctrl_q.done || decode_ill);
    assign illegal_instr = decode_ill;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expected control
// vectors, a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_instr;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ALUControl, ImmSrc;

    multicycle_control dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
        .instr_done(instr_done), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
    //  RegWrite, ImmSrc, instr_done, illegal_instr}
    function automatic logic [18:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic rw,
                                      input logic [2:0] imm, input logic done,
                                      input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, alu, rw, imm, done, ill};
    endfunction

    function automatic logic [18:0] fetch_v(input logic [2:0] imm);
        return v(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, imm, 1'b0, 1'b0);
    endfunction

    function automatic logic [18:0] decode_v(input logic [2:0] imm);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0, imm, 1'b0, 1'b0);
    endfunction

    function automatic logic [18:0] aluwb_v(input logic [2:0] imm);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, imm, 1'b1, 1'b0);
    endfunction

    task automatic step(input logic r, input logic [31:0] in, input logic z,
                        input logic [18:0] e, input string nm);
        @(posedge clk);
        #1;
        rst   = r;
        instr = in;
        Zero  = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run_alu(input logic [31:0] in, input logic is_r, input logic [2:0] alu,
                           input string nm);
        step(1'b0, in, 1'b0, fetch_v(3'b000), {nm, " fetch"});
        step(1'b0, in, 1'b0, decode_v(3'b000), {nm, " decode"});
        step(1'b0, in, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, is_r ? 2'b00 : 2'b01,
                                alu, 1'b0, 3'b000, 1'b0, 1'b0), {nm, " exec"});
        step(1'b0, in, 1'b0, aluwb_v(3'b000), {nm, " aluwb"});
    endtask

    task automatic run_br(input logic [31:0] in, input logic z, input logic pcw,
                          input string nm);
        step(1'b0, in, 1'b0, fetch_v(3'b010), {nm, " fetch"});
        step(1'b0, in, 1'b0, decode_v(3'b010), {nm, " decode"});
        step(1'b0, in, z, v(pcw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0,
                            3'b010, 1'b1, 1'b0), {nm, " branch"});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [18:0] e;
            logic [18:0] got;
            string       nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, RegWrite, ImmSrc, instr_done, illegal_instr};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got %b, required %b", nm, got, e);
            end
        end
    end

    localparam logic [31:0] SW  = 32'h00112223;
    localparam logic [31:0] LW  = 32'h00412083;

    initial begin
        rst   = 1'b1;
        instr = 32'h0;
        Zero  = 1'b0;
        step(1'b1, 32'h0, 1'b0, 19'd0, "reset 0");
        step(1'b1, 32'h0, 1'b0, 19'd0, "reset 1");

        // full store, then a store aborted by reset in MEMWRITE
        step(1'b0, SW, 1'b0, fetch_v(3'b001), "sw fetch");
        step(1'b0, SW, 1'b0, decode_v(3'b001), "sw decode");
        step(1'b0, SW, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0,
                               3'b001, 1'b0, 1'b0), "sw memadr");
        step(1'b0, SW, 1'b0, v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0,
                               3'b001, 1'b1, 1'b0), "sw memwrite");
        step(1'b0, SW, 1'b0, fetch_v(3'b001), "sw2 fetch");
        step(1'b0, SW, 1'b0, decode_v(3'b001), "sw2 decode");
        step(1'b0, SW, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0,
                               3'b001, 1'b0, 1'b0), "sw2 memadr");
        for (int i = 0; i < 3; i++) step(1'b1, SW, 1'b0, 19'd0, "reset mid memwrite");
        step(1'b0, SW, 1'b0, fetch_v(3'b001), "post-reset fetch");
        step(1'b0, SW, 1'b0, decode_v(3'b001), "sw3 decode");
        step(1'b0, SW, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0,
                               3'b001, 1'b0, 1'b0), "sw3 memadr");
        step(1'b0, SW, 1'b0, v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0,
                               3'b001, 1'b1, 1'b0), "sw3 memwrite");

        step(1'b0, LW, 1'b0, fetch_v(3'b000), "lw fetch");
        step(1'b0, LW, 1'b0, decode_v(3'b000), "lw decode");
        step(1'b0, LW, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0,
                               3'b000, 1'b0, 1'b0), "lw memadr");
        step(1'b0, LW, 1'b0, v(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0,
                               3'b000, 1'b0, 1'b0), "lw memread");
        step(1'b0, LW, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1,
                               3'b000, 1'b1, 1'b0), "lw memwb");

        run_alu(32'h40208033, 1'b1, 3'b001, "sub");
        run_alu(32'h00208033, 1'b1, 3'b000, "add");
        run_alu(32'h0020E033, 1'b1, 3'b011, "or");
        run_alu(32'h0020A033, 1'b1, 3'b101, "slt");
        run_alu(32'h0020C033, 1'b1, 3'b100, "xor");
        run_alu(32'h0FF0F093, 1'b0, 3'b010, "andi");
        run_alu(32'h40008093, 1'b0, 3'b000, "addi bit30");

        run_br(32'h00208463, 1'b1, 1'b1, "beq taken");
        run_br(32'h00208463, 1'b0, 1'b0, "beq not taken");
        run_br(32'h00209463, 1'b1, 1'b0, "bne zero");
        run_br(32'h00209463, 1'b0, 1'b1, "bne nonzero");
        run_br(32'h0020C463, 1'b1, 1'b0, "blt unsupported");

        step(1'b0, 32'h008000EF, 1'b0, fetch_v(3'b100), "jal fetch");
        step(1'b0, 32'h008000EF, 1'b0, decode_v(3'b100), "jal decode");
        step(1'b0, 32'h008000EF, 1'b0, v(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000,
                                        1'b0, 3'b100, 1'b0, 1'b0), "jal jal");
        step(1'b0, 32'h008000EF, 1'b0, aluwb_v(3'b100), "jal aluwb");

        step(1'b0, 32'h000080E7, 1'b0, fetch_v(3'b000), "jalr fetch");
        step(1'b0, 32'h000080E7, 1'b0, decode_v(3'b000), "jalr decode");
        step(1'b0, 32'h000080E7, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000,
                                        1'b0, 3'b000, 1'b0, 1'b0), "jalr jalr1");
        step(1'b0, 32'h000080E7, 1'b0, v(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000,
                                        1'b0, 3'b000, 1'b0, 1'b0), "jalr jalr2");
        step(1'b0, 32'h000080E7, 1'b0, aluwb_v(3'b000), "jalr aluwb");

        step(1'b0, 32'h123450B7, 1'b0, fetch_v(3'b011), "lui fetch");
        step(1'b0, 32'h123450B7, 1'b0, decode_v(3'b011), "lui decode");
        step(1'b0, 32'h123450B7, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 3'b000,
                                        1'b1, 3'b011, 1'b1, 1'b0), "lui lui");

        step(1'b0, 32'h00000097, 1'b0, fetch_v(3'b011), "auipc fetch");
        step(1'b0, 32'h00000097, 1'b0, decode_v(3'b011), "auipc decode");
        step(1'b0, 32'h00000097, 1'b0, aluwb_v(3'b011), "auipc aluwb");

        step(1'b0, 32'h0000007F, 1'b0, fetch_v(3'b000), "illegal fetch");
        step(1'b0, 32'h0000007F, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000,
                                        1'b0, 3'b000, 1'b1, 1'b1), "illegal decode");
        run_alu(32'h00208033, 1'b1, 3'b000, "add after illegal");

        repeat (2) @(posedge clk);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM for the multicycle RV32I core.
- Sequences the shared ALU, memory port, PC register, instruction register and register file.
- Drives `ImmSrc` to the immediate extender (000 I, 001 S, 010 B, 011 U, 100 J).
- Sits between the instruction register and datapath muxes. Each instruction takes 3–5 cycles.

Parameters:
- `RESET_STATE`, FETCH: state entered on reset. Fixed; exposed for bring-up only.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 32: instruction register contents. Uses op [6:0], funct3 [14:12], funct7b5 [30].
- `Zero` in 1: ALU result == 0.
- `PCWrite` out 1: PC register load.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = Result.
- `MemWrite` out 1: data memory write strobe.
- `IRWrite` out 1: instruction register / OldPC load.
- `ResultSrc` out 2: 00 ALUOut, 01 ReadData, 10 ALUResult, 11 ImmExt.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB` out 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- `RegWrite` out 1: register file write.
- `ImmSrc` out 3: extender format select.
- `instr_done` out 1: high in the final cycle of each instruction.
- `illegal_instr` out 1: one-cycle pulse in DECODE for an unsupported opcode.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high. While `rst` = 1, the state loads FETCH at each edge.
- Output forcing during reset: `PCWrite`, `MemWrite`, `IRWrite`, `RegWrite`, `instr_done` and `illegal_instr` are forced to 0. All mux selects, `ALUControl` and `ImmSrc` read 0.
- After `rst` falls, the first cycle is FETCH.
- Mid-instruction reset: aborts the instruction with no write strobes.
- `ImmSrc` decoding (combinational from op, all states):
  - lw / I-ALU / jalr → 000
  - sw → 001
  - branch → 010
  - lui / auipc → 011
  - jal → 100
  - otherwise → 000
- Output defaults: outputs not listed for a state are 0.
- States (outputs; → next state):
  - FETCH: `AdrSrc`=0, `IRWrite`, `ALUSrcA`=00, `ALUSrcB`=10, add, `ResultSrc`=10, `PCWrite` → DECODE.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01, add (ALUOut ← OldPC+imm). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR1
    - 0110111 → LUI
    - 0010111 → ALUWB (auipc)
    - else: `illegal_instr`=1, `instr_done`=1 → FETCH
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, add → MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: `AdrSrc`=1, `ResultSrc`=00 → MEMWB.
  - MEMWB: `ResultSrc`=01, `RegWrite`, `instr_done` → FETCH.
  - MEMWRITE: `AdrSrc`=1, `ResultSrc`=00, `MemWrite`, `instr_done` → FETCH.
  - EXECR: `ALUSrcA`=10, `ALUSrcB`=00, decoded ALU op → ALUWB.
  - EXECI: `ALUSrcA`=10, `ALUSrcB`=01, decoded ALU op → ALUWB.
  - ALUWB: `ResultSrc`=00, `RegWrite`, `instr_done` → FETCH.
  - BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, sub, `ResultSrc`=00, `instr_done` → FETCH.
    - `PCWrite` = (funct3 == 000 & `Zero`) | (funct3 == 001 & !`Zero`).
    - Other funct3 values: `PCWrite`=0.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, add, `ResultSrc`=00, `PCWrite` → ALUWB.
  - JALR1: `ALUSrcA`=10, `ALUSrcB`=01, add → JALR2.
  - JALR2: `ALUSrcA`=01, `ALUSrcB`=10, add, `ResultSrc`=00, `PCWrite` → ALUWB.
  - LUI: `ResultSrc`=11, `RegWrite`, `instr_done` → FETCH.
- ALU decode (EXECR / EXECI), by funct3:
  - 000: sub if EXECR & funct7b5, else add.
  - 111: and. 110: or. 100: xor. 010: slt.
  - Others: add.
- Latency in cycles including FETCH:
  - lw 5, jalr 5
  - sw 4, R 4, I 4, jal 4
  - beq/bne 3, lui 3, auipc 3
  - illegal 2
- `instr_done` asserts exactly once per instruction.
- Unreachable state encodings → FETCH on the next edge, with no strobes.

Test Plan:
- Reset held 3 cycles mid-MEMWRITE → `MemWrite`=0 during reset; first post-reset cycle is FETCH with `IRWrite`=1, `PCWrite`=1.
- lw 0x00412083 → DECODE→MEMADR→MEMREAD→MEMWB:
  - `ImmSrc`=000 throughout.
  - MEMREAD `AdrSrc`=1.
  - MEMWB `RegWrite`=1, `ResultSrc`=01, `instr_done`=1 in cycle 5.
- R-type sub 0x40208033 → EXECR `ALUControl`=001; add 0x00208033 → 000; both take 4 cycles with `RegWrite` only in ALUWB.
- beq 0x00208463:
  - `Zero`=1 → `PCWrite`=1 in BRANCH, `ImmSrc`=010.
  - `Zero`=0 → `PCWrite`=0.
  - bne (funct3 001) gives the inverse.
- jal 0x008000EF → `ImmSrc`=100, `PCWrite` in JAL, `RegWrite` in ALUWB, 4 cycles. jalr 0x000080E7 → 5 cycles, `PCWrite` in JALR2.
- lui 0x123450B7 → LUI `ResultSrc`=11, `ImmSrc`=011, 3 cycles. Opcode 0x0000007F → `illegal_instr`=1 in DECODE, back to FETCH, no writes.
